// File: rtl/vga_sprite_pkg.sv
// Shared definitions for the mouse sprite slot: register offsets, the
// RAM/control select bit and the loader FSM states.
package vga_sprite_pkg;

  localparam int SLOT_ADDR_W  = 14;
  localparam int SLOT_DATA_W  = 32;
  localparam int CTRL_SEL_BIT = 13;

  localparam logic [1:0] REG_BYPASS = 2'b00;
  localparam logic [1:0] REG_X0     = 2'b01;
  localparam logic [1:0] REG_Y0     = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    POS_X,
    POS_Y,
    BYP
  } loader_state_t;

  // Slot address of a control register: select bit set, offset in the low bits.
  function automatic logic [SLOT_ADDR_W-1:0] ctrl_addr(input logic [1:0] reg_sel);
    logic [SLOT_ADDR_W-1:0] a;
    a               = '0;
    a[CTRL_SEL_BIT] = 1'b1;
    a[1:0]          = reg_sel;
    return a;
  endfunction

endpackage

// File: rtl/sprite_pos_clamp.sv
// Combinational clamp keeping the sprite origin inside the visible area.
module sprite_pos_clamp #(
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int SPRITE_SIZE = 32
) (
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  output logic [10:0] clamp_x,
  output logic [10:0] clamp_y
);

  localparam logic [10:0] X_LIM = 11'(H_MAX - SPRITE_SIZE);
  localparam logic [10:0] Y_LIM = 11'(V_MAX - SPRITE_SIZE);

  assign clamp_x = (pos_x > X_LIM) ? X_LIM : pos_x;
  assign clamp_y = (pos_y > Y_LIM) ? Y_LIM : pos_y;

endmodule

// File: rtl/vga_sprite_mouse_loader.sv
// Slot bus initiator for the mouse sprite core: streams the bitmap ROM into
// sprite RAM on start and forwards clamped position / bypass updates.
module vga_sprite_mouse_loader
  import vga_sprite_pkg::*;
#(
  parameter int CD          = 12,
  parameter int ADDR        = 10,
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int SPRITE_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR-1:0]        rom_addr,
  input  logic [CD-1:0]          rom_data,
  input  logic                   pos_valid,
  input  logic [10:0]            pos_x,
  input  logic [10:0]            pos_y,
  input  logic                   byp_valid,
  input  logic                   byp_in,
  output logic                   cs,
  output logic                   write,
  output logic [SLOT_ADDR_W-1:0] addr,
  output logic [SLOT_DATA_W-1:0] wr_data
);

  loader_state_t state_reg, state_next;

  logic [ADDR-1:0]        rom_addr_reg, rom_addr_next;
  logic [ADDR:0]          req_cnt_reg, req_cnt_next;
  logic                   dat_vld_reg, dat_vld_next;
  logic [ADDR-1:0]        dat_addr_reg, dat_addr_next;
  logic                   wr_last_reg, wr_last_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   cs_reg, cs_next;
  logic                   write_reg, write_next;
  logic [SLOT_ADDR_W-1:0] addr_reg, addr_next;
  logic [SLOT_DATA_W-1:0] wr_data_reg, wr_data_next;
  logic                   pos_pend_reg, pos_pend_next;
  logic [10:0]            pos_x_pend_reg, pos_x_pend_next;
  logic [10:0]            pos_y_pend_reg, pos_y_pend_next;
  logic [10:0]            pos_y_cur_reg, pos_y_cur_next;
  logic                   byp_pend_reg, byp_pend_next;
  logic                   byp_val_reg, byp_val_next;

  logic [10:0] clamp_x, clamp_y;

  sprite_pos_clamp #(
    .H_MAX      (H_MAX),
    .V_MAX      (V_MAX),
    .SPRITE_SIZE(SPRITE_SIZE)
  ) u_clamp (
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .clamp_x(clamp_x),
    .clamp_y(clamp_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rom_addr_reg   <= '0;
      req_cnt_reg    <= '0;
      dat_vld_reg    <= 1'b0;
      dat_addr_reg   <= '0;
      wr_last_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cs_reg         <= 1'b0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wr_data_reg    <= '0;
      pos_pend_reg   <= 1'b0;
      pos_x_pend_reg <= '0;
      pos_y_pend_reg <= '0;
      pos_y_cur_reg  <= '0;
      byp_pend_reg   <= 1'b0;
      byp_val_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rom_addr_reg   <= rom_addr_next;
      req_cnt_reg    <= req_cnt_next;
      dat_vld_reg    <= dat_vld_next;
      dat_addr_reg   <= dat_addr_next;
      wr_last_reg    <= wr_last_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      cs_reg         <= cs_next;
      write_reg      <= write_next;
      addr_reg       <= addr_next;
      wr_data_reg    <= wr_data_next;
      pos_pend_reg   <= pos_pend_next;
      pos_x_pend_reg <= pos_x_pend_next;
      pos_y_pend_reg <= pos_y_pend_next;
      pos_y_cur_reg  <= pos_y_cur_next;
      byp_pend_reg   <= byp_pend_next;
      byp_val_reg    <= byp_val_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rom_addr_next   = rom_addr_reg;
    req_cnt_next    = req_cnt_reg;
    dat_vld_next    = dat_vld_reg;
    dat_addr_next   = dat_addr_reg;
    wr_last_next    = 1'b0;
    done_next       = 1'b0;
    cs_next         = 1'b0;
    write_next      = 1'b0;
    addr_next       = '0;
    wr_data_next    = '0;
    pos_pend_next   = pos_pend_reg;
    pos_x_pend_next = pos_x_pend_reg;
    pos_y_pend_next = pos_y_pend_reg;
    pos_y_cur_next  = pos_y_cur_reg;
    byp_pend_next   = byp_pend_reg;
    byp_val_next    = byp_val_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = LOAD;
          rom_addr_next = '0;
          req_cnt_next  = '0;
          dat_vld_next  = 1'b0;
        end else if (pos_pend_reg) begin
          state_next = POS_X;
        end else if (byp_pend_reg) begin
          state_next = BYP;
        end
      end

      LOAD: begin
        // Address issue stage: the ROM samples rom_addr, data returns next cycle.
        if (!req_cnt_reg[ADDR]) begin
          dat_vld_next  = 1'b1;
          dat_addr_next = rom_addr_reg;
          req_cnt_next  = req_cnt_reg + 1'b1;
          if (rom_addr_reg != '1) begin
            rom_addr_next = rom_addr_reg + 1'b1;
          end
        end else begin
          dat_vld_next = 1'b0;
        end

        if (dat_vld_reg) begin
          cs_next      = 1'b1;
          write_next   = 1'b1;
          addr_next    = {{(SLOT_ADDR_W-ADDR){1'b0}}, dat_addr_reg};
          wr_data_next = {{(SLOT_DATA_W-CD){1'b0}}, rom_data};
          wr_last_next = &dat_addr_reg;
        end

        if (wr_last_reg) begin
          done_next     = 1'b1;
          rom_addr_next = '0;
          dat_vld_next  = 1'b0;
          if (pos_pend_reg)      state_next = POS_X;
          else if (byp_pend_reg) state_next = BYP;
          else                   state_next = IDLE;
        end
      end

      POS_X: begin
        cs_next        = 1'b1;
        write_next     = 1'b1;
        addr_next      = ctrl_addr(REG_X0);
        wr_data_next   = {21'd0, pos_x_pend_reg};
        // Freeze y so a request arriving now cannot tear the x/y pair.
        pos_y_cur_next = pos_y_pend_reg;
        pos_pend_next  = 1'b0;
        state_next     = POS_Y;
      end

      POS_Y: begin
        cs_next      = 1'b1;
        write_next   = 1'b1;
        addr_next    = ctrl_addr(REG_Y0);
        wr_data_next = {21'd0, pos_y_cur_reg};
        if (byp_pend_reg)      state_next = BYP;
        else if (pos_pend_reg) state_next = POS_X;
        else                   state_next = IDLE;
      end

      BYP: begin
        cs_next       = 1'b1;
        write_next    = 1'b1;
        addr_next     = ctrl_addr(REG_BYPASS);
        wr_data_next  = {31'd0, byp_val_reg};
        byp_pend_next = 1'b0;
        state_next    = pos_pend_reg ? POS_X : IDLE;
      end

      default: state_next = IDLE;
    endcase

    // New requests override any clear above, so nothing is ever dropped.
    if (pos_valid) begin
      pos_pend_next   = 1'b1;
      pos_x_pend_next = clamp_x;
      pos_y_pend_next = clamp_y;
    end
    if (byp_valid) begin
      byp_pend_next = 1'b1;
      byp_val_next  = byp_in;
    end

    busy_next = (state_next != IDLE);
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rom_addr = rom_addr_reg;
  assign cs       = cs_reg;
  assign write    = write_reg;
  assign addr     = addr_reg;
  assign wr_data  = wr_data_reg;

endmodule

// File: tb/tb_vga_sprite_mouse_loader.sv
// Scoreboard bench for vga_sprite_mouse_loader: stimulus pushes expected slot
// writes, a negedge monitor pops and compares every write the DUT issues.
module tb_vga_sprite_mouse_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic        pos_valid;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        byp_valid;
  logic        byp_in;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ram_wr_cnt = 0;
  bit   prev_last = 0;
  bit   expect_next = 0;

  vga_sprite_mouse_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pos_valid(pos_valid),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .byp_valid(byp_valid),
    .byp_in   (byp_in),
    .cs       (cs),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous bitmap ROM whose content equals its address.
  always @(posedge clk) rom_data <= {2'b00, rom_addr};

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      checks++;
      if (cs !== 1'b0 || write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: cs=%b write=%b done=%b busy=%b, required all 0",
                 cs, write, done, busy);
      end
      prev_last   = 0;
      expect_next = 0;
      ram_wr_cnt  = 0;
    end else begin
      checks++;
      if (done !== prev_last) begin
        errors++;
        $display("FAIL done_timing: done=%b, required %b", done, prev_last);
      end
      if (done === 1'b1) begin
        checks++;
        if (ram_wr_cnt != 1024) begin
          errors++;
          $display("FAIL load_count: %0d RAM writes, required 1024", ram_wr_cnt);
        end
        ram_wr_cnt = 0;
      end
      if (expect_next) begin
        checks++;
        if (!(cs === 1'b1 && write === 1'b1)) begin
          errors++;
          $display("FAIL back_to_back: cs=%b write=%b, required consecutive write", cs, write);
        end
      end
      checks++;
      if (cs !== write) begin
        errors++;
        $display("FAIL cs_write_pair: cs=%b write=%b, required equal", cs, write);
      end
      if (cs === 1'b1 && write === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", addr, wr_data);
        end else begin
          e = sb.pop_front();
          if (addr !== e.a || wr_data !== e.d) begin
            errors++;
            $display("FAIL slot_write: addr=%h data=%h, required addr=%h data=%h",
                     addr, wr_data, e.a, e.d);
          end else begin
            $display("write addr=%h data=%h ok", addr, wr_data);
          end
        end
        if (addr[13] == 1'b0) ram_wr_cnt++;
        prev_last   = (addr == 14'h03FF);
        expect_next = (addr[13] == 1'b0 && addr[9:0] != 10'h3FF) || (addr == 14'h2001);
      end else begin
        checks++;
        if (addr !== 14'h0 || wr_data !== 32'h0) begin
          errors++;
          $display("FAIL idle_bus: addr=%h data=%h, required 0", addr, wr_data);
        end
        prev_last   = 0;
        expect_next = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_load();
    for (int i = 0; i < 1024; i++) push(14'(i), 32'(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_pos(input logic [10:0] x, input logic [10:0] y);
    pos_valid = 1'b1;
    pos_x = x;
    pos_y = y;
    tick();
    pos_valid = 1'b0;
  endtask

  task automatic pulse_byp(input logic b);
    byp_valid = 1'b1;
    byp_in = b;
    tick();
    byp_valid = 1'b0;
  endtask

  task automatic wait_pixels(input int n, input string name);
    int cyc;
    cyc = 0;
    while (ram_wr_cnt < n && cyc < 3000) begin
      tick();
      cyc++;
    end
    checks++;
    if (ram_wr_cnt != n) begin
      errors++;
      $display("FAIL %s: reached %0d RAM writes, required %0d", name, ram_wr_cnt, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && cyc < 3000) begin
      tick();
      cyc++;
    end
    repeat (2) tick();
    checks++;
    if (sb.size() != 0 || busy !== 1'b0 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%b rom_addr=%0d, required 0/0/0",
               name, sb.size(), busy, rom_addr);
    end
    sb.delete();
  endtask

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] ex;
    logic [10:0] ey;
  } pos_vec_t;

  pos_vec_t pos_tab[5] = '{
    '{11'd100,  11'd200,  11'd100, 11'd200},
    '{11'd700,  11'd470,  11'd608, 11'd448},
    '{11'd608,  11'd448,  11'd608, 11'd448},
    '{11'd609,  11'd2047, 11'd608, 11'd448},
    '{11'd0,    11'd0,    11'd0,   11'd0}
  };

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pos_valid = 1'b0;
    pos_x = '0;
    pos_y = '0;
    byp_valid = 1'b0;
    byp_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (addr !== 14'h0 || wr_data !== 32'h0 || rom_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h rom_addr=%h, required 0", addr, wr_data, rom_addr);
    end
    reset = 1'b0;
    tick();

    // Plain bitmap load.
    push_load();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL load_start: busy=%b rom_addr=%0d, required 1/0", busy, rom_addr);
    end
    wait_drain("load");

    // Position writes, including clamp boundaries.
    foreach (pos_tab[i]) begin
      push(14'h2001, {21'd0, pos_tab[i].ex});
      push(14'h2002, {21'd0, pos_tab[i].ey});
      pulse_pos(pos_tab[i].x, pos_tab[i].y);
      wait_drain("pos");
    end

    // Position and bypass in the same idle cycle: position first.
    push(14'h2001, 32'd100);
    push(14'h2002, 32'd5);
    push(14'h2000, 32'd0);
    pos_valid = 1'b1;
    pos_x = 11'd100;
    pos_y = 11'd5;
    byp_valid = 1'b1;
    byp_in = 1'b0;
    tick();
    pos_valid = 1'b0;
    byp_valid = 1'b0;
    wait_drain("pos_byp");

    // Requests held during a load, plus an ignored restart.
    push_load();
    push(14'h2001, 32'd30);
    push(14'h2002, 32'd40);
    push(14'h2000, 32'd1);
    pulse_start();
    wait_pixels(100, "load_req_wait");
    pulse_pos(11'd10, 11'd20);
    pulse_pos(11'd30, 11'd40);
    pulse_byp(1'b1);
    wait_pixels(500, "load_restart_wait");
    pulse_start();
    wait_drain("load_req");

    // Reset mid-load aborts everything.
    push_load();
    pulse_start();
    wait_pixels(300, "abort_wait");
    reset = 1'b1;
    sb.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || cs !== 1'b0 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b cs=%b rom_addr=%0d, required 0/0/0", busy, cs, rom_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
